w_hc4511_scan: RTL and testbench
================================

# w_hc4511_scan

Parametrised multi-digit successor to the single-digit 4511-style hex decoder. It latches a packed vector of hex nibbles and decimal points under an active-low latch enable. It time-multiplexes the digits onto one shared 8-bit segment bus with a one-hot digit select, and adds leading-zero blanking and an anti-ghosting dark cycle. It sits between the counter/datapath logic and the board's common-cathode/anode LED display.

## Interface
- DIGITS, 8, number of digits scanned (>=2).
- SCAN_DIV, 50000, clock cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 0, 1 = invert `seg` at the output register.
- DIG_ACTIVE_LOW, 0, 1 = invert `dig_sel` at the output register.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- le  in  1  latch enable, active-low: 0 = transparent load every clock, 1 = hold.
- bi_n  in  1  blanking, active-low.
- lt_n  in  1  lamp test, active-low; overrides `bi_n`.
- lzb  in  1  1 = leading-zero blanking enabled.
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is least significant.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- seg  out  8  segments: bit0=a … bit6=g, bit7=dp; active-high before the polarity parameter is applied.
- dig_sel  out  DIGITS  one-hot digit enable.

## Operation
- Latch: `data_q`/`dp_q` load `data`/`dp` on every clock edge while le=0 and hold while le=1. Changes are not visible on the outputs while le=1.
- Scan: `div_cnt` counts 0..SCAN_DIV-1 and wraps. When `div_cnt`=SCAN_DIV-1, `idx` advances; DIGITS-1 wraps to 0.
- Hex segment codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71. Bit7 = dp_q[idx].
- Leading-zero blank for digit i (i>=1):
  - Applies when lzb=1 and nibbles i..DIGITS-1 of `data_q` are all 0.
  - A blanked digit gives seg=00 including dp, but `dig_sel` is still driven.
  - Digit 0 is never blanked.
- Output priority, evaluated on the current state:
  - lt_n=0 → seg=FF; `dig_sel` scans normally.
  - Else bi_n=0 → seg=00 and dig_sel all inactive.
  - Else the decoded digit, or the LZB blank.
- Dark cycle: while `div_cnt`=0, dig_sel is all inactive and `seg` still carries the decode. This also applies under lamp test. Each slot is therefore 1 dark cycle plus SCAN_DIV-1 lit cycles.
- Polarity: the inversion parameters apply only at the output registers. "Inactive" means 0 when the parameter is 0, and 1 when it is 1.

## Timing
- Reset (async assert, takes effect immediately):
  - data_q=0, dp_q=0, idx=0, div_cnt=0.
  - seg = all segments off; dig_sel = all inactive, at the configured polarity.
- `seg` and `dig_sel` are registered from the current idx, div_cnt, data_q, dp_q and the control inputs, so they lag the state by one cycle.
- data→seg latency:
  - 1 cycle to `data_q` (le=0), plus 1 cycle to `seg`.
  - This holds only while that digit is the one being scanned.
  - Worst case is 2 + DIGITS*SCAN_DIV cycles.
- Control inputs (lt_n, bi_n, lzb) affect the outputs 1 cycle after they change. They do not disturb the scan counters.
- Full-frame period: DIGITS*SCAN_DIV cycles.
- Reset asserted mid-scan: outputs go inactive immediately. After release, scanning restarts at idx=0, beginning with its dark cycle.
- le toggling mid-slot: a new value may change `seg` within the current slot. This is legal.

## Test plan
Bench configuration for every scenario: DIGITS=4, SCAN_DIV=4, active-high polarity.
- Reset and scan order:
  - Stimulus: hold rst_n=0, then release with data=0.
  - Required: seg=00 and dig_sel=0 during reset. After release, dig_sel runs 0 (dark cycle), then 0001 for 3 cycles, 0, 0010 ×3, 0, 0100 ×3, 0, 1000 ×3, then repeats.
- Latch:
  - Stimulus: le=0 with data=1234; then le=1 and data=FFFF.
  - Required: digit0 shows 66, digit1 4F, digit2 5B, digit3 06. The displayed values stay unchanged after le=1.
- LZB:
  - Stimulus: lzb=1 with data=0050, then data=0000.
  - Required for 0050: digits 3 and 2 give seg=00 with dig_sel still active; digit1 gives 6D; digit0 gives 3F.
  - Required for 0000: only digit0 shows 3F.
  - Required with lzb=0 and data=0000: all digits show 3F.
- Priority:
  - Stimulus: lt_n=0 with bi_n=0.
  - Required: seg=FF on every digit and dig_sel scanning.
  - Then with lt_n=1, bi_n=0: seg=00 and dig_sel=0 one cycle later.
- Decimal point:
  - Stimulus: dp=0100 with data=8888.
  - Required: digit2 gives seg=FF; the other digits give 7F.
- Async reset mid-scan:
  - Stimulus: assert rst_n=0 while idx=2, between clock edges.
  - Required: outputs go inactive without waiting for a clock edge. After release, the first lit digit is 0 and the display shows 3F (data_q cleared).

Source files
------------

// File: rtl/w_hc4511_scan.sv
// Multi-digit scanned hex-to-7-segment driver: latched nibbles, leading-zero blanking,
// lamp test / blanking priority and a dark cycle at the start of every digit slot.
module w_hc4511_scan #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_le,
    input  logic                  i_bi_n,
    input  logic                  i_lt_n,
    input  logic                  i_lzb,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_dig_sel
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;
    logic [IDX_W-1:0]    r_idx;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_sel;

    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blank;
    logic [DIGITS:0]     w_zero_from;
    logic [DIGITS-1:0]   w_onehot;
    logic [7:0]          w_seg;
    logic [DIGITS-1:0]   w_dig_sel;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_dp   <= '0;
        end else if (!i_le) begin
            r_data <= i_data;
            r_dp   <= i_dp;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // w_zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        w_nib       = '0;
        w_dp        = 1'b0;
        w_blank     = 1'b0;
        w_onehot    = '0;
        w_zero_from = '0;
        w_zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] & (r_data[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_data[4*i +: 4];
                w_dp        = r_dp[i];
                w_onehot[i] = 1'b1;
                w_blank     = i_lzb && (i != 0) && w_zero_from[i];
            end
        end
    end

    always_comb begin
        w_seg     = '0;
        w_dig_sel = (r_div_cnt == '0) ? '0 : w_onehot;
        if (!i_lt_n) begin
            w_seg = 8'hFF;
        end else if (!i_bi_n) begin
            w_seg     = 8'h00;
            w_dig_sel = '0;
        end else if (!w_blank) begin
            w_seg = {w_dp, hex7(w_nib)};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg     <= {8{SEG_ACTIVE_LOW}};
            r_dig_sel <= {DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            r_seg     <= w_seg ^ {8{SEG_ACTIVE_LOW}};
            r_dig_sel <= w_dig_sel ^ {DIGITS{DIG_ACTIVE_LOW}};
        end
    end

    assign o_seg     = r_seg;
    assign o_dig_sel = r_dig_sel;

endmodule

// File: tb/tb_w_hc4511_scan.sv
// Scoreboard bench for w_hc4511_scan (DIGITS=4, SCAN_DIV=4): stimulus queues expected
// per-cycle {dig_sel, seg} values for whole frames; a negedge monitor pops and compares.
module tb_w_hc4511_scan;

    typedef struct packed {
        logic [15:0] tag;
        logic [3:0]  dig;
        logic [7:0]  seg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        le;
    logic        bi_n;
    logic        lt_n;
    logic        lzb;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;

    exp_t sb_q[$];
    int   n_total;
    int   n_pass;
    int   k;

    w_hc4511_scan #(
        .DIGITS         (4),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_le      (le),
        .i_bi_n    (bi_n),
        .i_lt_n    (lt_n),
        .i_lzb     (lzb),
        .i_data    (data),
        .i_dp      (dp),
        .o_seg     (seg),
        .o_dig_sel (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; output after edge k shows scan state k-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: dig_sel/seg got %h, required %h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("frame%0d", e.tag), {dig_sel, seg}, {e.dig, e.seg});
        end
    end

    task automatic push(input logic [15:0] tag, input logic [3:0] d, input logic [7:0] s);
        exp_t e;
        e.tag = tag;
        e.dig = d;
        e.seg = s;
        sb_q.push_back(e);
    endtask

    // One frame: per digit a dark cycle then three lit cycles.
    task automatic push_frame(input logic [15:0] tag, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input bit on);
        logic [7:0] s [4];
        logic [3:0] oh;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            oh = 4'b0001 << d;
            push(tag, 4'b0000, s[d]);
            for (int j = 0; j < 3; j++) push(tag, on ? oh : 4'b0000, s[d]);
        end
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((k - 1) % 16 != 0) && n < 40);
        if (n >= 40) chk("sync_timeout", 12'h001, 12'h000);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            chk("drain_timeout", 12'h001, 12'h000);
            sb_q.delete();
        end
    endtask

    task automatic show(input logic [15:0] tag, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input bit on);
        repeat (2) @(posedge clk);
        sync_frame();
        push_frame(tag, s0, s1, s2, s3, on);
        drain();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0; le = 1'b0; bi_n = 1'b1; lt_n = 1'b1; lzb = 1'b0;
        data  = 16'h0000; dp = 4'b0000;
        #2;
        chk("reset_async", {dig_sel, seg}, 12'h000);
        push(16'd0, 4'b0000, 8'h00);
        push(16'd0, 4'b0000, 8'h00);
        push(16'd0, 4'b0000, 8'h00);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        sync_frame();
        push_frame(16'd1, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1);
        drain();
        push_frame(16'd2, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1);
        drain();

        data = 16'h1234;
        show(16'd3, 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b1);
        le = 1'b1; data = 16'hFFFF;
        show(16'd4, 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b1);

        le = 1'b0; lzb = 1'b1; data = 16'h0050;
        show(16'd5, 8'h3F, 8'h6D, 8'h00, 8'h00, 1'b1);
        data = 16'h0000;
        show(16'd6, 8'h3F, 8'h00, 8'h00, 8'h00, 1'b1);
        lzb = 1'b0;
        show(16'd7, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1);

        lt_n = 1'b0; bi_n = 1'b0;
        show(16'd8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        lt_n = 1'b1;
        @(posedge clk);
        #1;
        chk("blank_one_cycle", {dig_sel, seg}, 12'h000);
        show(16'd9, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        bi_n = 1'b1; dp = 4'b0100; data = 16'h8888;
        show(16'd10, 8'h7F, 8'h7F, 8'hFF, 8'h7F, 1'b1);

        // Land inside digit 2's lit cycles, then reset between edges.
        sync_frame();
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_idx2", {dig_sel, seg}, {4'b0100, 8'hFF});
        #2;
        rst_n = 1'b0;
        le    = 1'b1;
        #1;
        chk("mid_scan_reset", {dig_sel, seg}, 12'h000);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        sync_frame();
        push_frame(16'd11, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
